// File: rtl/csa_stream_accumulator.sv
// csa_stream_accumulator
//
// Multi-operand adder stage. Accepts a stream of WIDTH-bit operands over a
// valid/ready handshake. Operands are accumulated in carry-save form, with one
// 3:2 compression per accepted beat and no carry propagation. When the last
// operand arrives, sum and carry are resolved with a single add. The total is
// then held on an output valid/ready handshake.
//
// Optional build macro CSA_SIGNED_EN:
//   defined   - operands are two's complement and are sign-extended to OUT_W.
//   undefined - operands are unsigned and are zero-extended to OUT_W.
// In both builds the accumulation arithmetic is modulo 2^OUT_W.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        asynchronous, active-high reset
//   i_start      in IDLE, clears the accumulators and begins an accumulation
//   i_in_valid   operand valid
//   o_in_ready   block accepts an operand this cycle (ACC state only)
//   i_in_data    operand, WIDTH bits
//   i_in_last    marks i_in_data as the final operand
//   o_out_valid  result valid (DONE state)
//   i_out_ready  consumer accepts the result
//   o_out_sum    resolved total, OUT_W bits
//   o_out_count  number of operands summed, CNT_W bits
//
// State     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for i_start; operands are not consumed
// S_ACC     | accepting operands; one carry-save compression per beat
// S_RESOLVE | single cycle: sum + carry captured into the output registers
// S_DONE    | result presented until the output handshake completes

module csa_stream_accumulator #(
    parameter int WIDTH   = 4,
    parameter int MAX_OPS = 8,
    localparam int CNT_W  = $clog2(MAX_OPS + 1),
    localparam int OUT_W  = WIDTH + $clog2(MAX_OPS + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_last,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [OUT_W-1:0] o_out_sum,
    output logic [CNT_W-1:0] o_out_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACC     = 2'd1,
        S_RESOLVE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [OUT_W-1:0] r_sum;
    logic [OUT_W-1:0] r_carry;
    logic [CNT_W-1:0] r_count;
    logic [OUT_W-1:0] r_out_sum;
    logic [CNT_W-1:0] r_out_count;

    logic [OUT_W-1:0] w_x;
    logic [OUT_W-1:0] w_maj;
    logic [OUT_W-1:0] w_carry_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_beat;
    logic             w_clear;
    logic             w_in_ready;
    logic             w_out_valid;

`ifdef CSA_SIGNED_EN
    assign w_x = {{(OUT_W - WIDTH){i_in_data[WIDTH-1]}}, i_in_data};
`else
    assign w_x = {{(OUT_W - WIDTH){1'b0}}, i_in_data};
`endif

    // Majority of the three inputs, shifted up one place. The bit shifted out
    // of the top is dropped; OUT_W is wide enough that this cannot lose
    // information for a legal operand count.
    assign w_maj       = (r_sum & r_carry) | (r_sum & w_x) | (r_carry & w_x);
    assign w_carry_nxt = {w_maj[OUT_W-2:0], 1'b0};
    assign w_count_nxt = r_count + 1'b1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_beat      = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // An operand presented together with start is not consumed.
                if (i_start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = S_ACC;
                end
            end
            S_ACC: begin
                w_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_beat = 1'b1;
                    if (i_in_last || (w_count_nxt == CNT_W'(MAX_OPS))) begin
                        w_state_nxt = S_RESOLVE;
                    end
                end
            end
            S_RESOLVE: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sum       <= '0;
            r_carry     <= '0;
            r_count     <= '0;
            r_out_sum   <= '0;
            r_out_count <= '0;
        end else begin
            if (w_clear) begin
                r_sum   <= '0;
                r_carry <= '0;
                r_count <= '0;
            end else if (w_beat) begin
                r_sum   <= r_sum ^ r_carry ^ w_x;
                r_carry <= w_carry_nxt;
                r_count <= w_count_nxt;
            end
            if (r_state == S_RESOLVE) begin
                r_out_sum   <= r_sum + r_carry;
                r_out_count <= r_count;
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    assign o_out_sum   = r_out_sum;
    assign o_out_count = r_out_count;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
module tb_csa_stream_accumulator;

    localparam int WIDTH   = 4;
    localparam int MAX_OPS = 8;
    localparam int OUT_W   = 8;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;

    csa_stream_accumulator #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .i_in_last   (in_last),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_sum   (out_sum),
        .o_out_count (out_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard of expected {sum, count}, pushed when the final beat is accepted.
    logic [OUT_W+CNT_W-1:0] sb_q[$];
    int m_sum;
    int m_cnt;
    logic [OUT_W-1:0] last_sum;
    logic [CNT_W-1:0] last_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ext(input logic [WIDTH-1:0] d);
`ifdef CSA_SIGNED_EN
        return int'($signed(d));
`else
        return int'(d);
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_accept(input logic [WIDTH-1:0] d, input logic last);
        m_sum += ext(d);
        m_cnt++;
        if (last || m_cnt == MAX_OPS)
            sb_q.push_back({OUT_W'(m_sum), CNT_W'(m_cnt)});
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        m_sum = 0;
        m_cnt = 0;
    endtask

    task automatic send_beat(input logic [WIDTH-1:0] d, input logic last);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int i = 0; i < 20 && !done; i++) begin
            if (in_ready) begin
                step();
                model_accept(d, last);
                done = 1'b1;
            end else begin
                step();
            end
        end
        if (!done) check("beat_accept_timeout", in_ready, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called one step after the accepting edge of the final beat.
    task automatic get_result(input string tag, input bit chk_lat);
        int waited;
        logic [OUT_W+CNT_W-1:0] exp;
        waited = 0;
        if (chk_lat) check({tag, "_resolve_not_valid"}, out_valid, 0);
        while (!out_valid && waited < 20) begin
            step();
            waited++;
        end
        check({tag, "_out_valid"}, out_valid, 1);
        if (chk_lat) check({tag, "_latency"}, waited, 1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, sb_q.size(), 1);
            return;
        end
        exp = sb_q.pop_front();
        last_sum = out_sum;
        last_cnt = out_count;
        check({tag, "_sum"}, out_sum, exp[OUT_W+CNT_W-1:CNT_W]);
        check({tag, "_count"}, out_count, exp[CNT_W-1:0]);
        if (out_ready) begin
            step();
            check({tag, "_valid_clear"}, out_valid, 0);
            check({tag, "_idle_ready"}, in_ready, 0);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_sum"}, out_sum, 0);
        check({tag, "_out_count"}, out_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        out_ready = 1'b1; m_sum = 0; m_cnt = 0; last_sum = '0; last_cnt = '0;
        step();
        step();
        check_zero("reset");
        rst = 1'b0;
        step();

        // Operand in IDLE is not consumed, including the start cycle.
        in_valid = 1'b1; in_data = 4'd7;
        step();
        check("idle_ready", in_ready, 0);
        start = 1'b1;
        step();
        start = 1'b0; in_valid = 1'b0;
        m_sum = 0; m_cnt = 0;
        check("acc_ready", in_ready, 1);

        // Basic
        send_beat(4'd13, 1'b0);
        send_beat(4'd9, 1'b0);
        send_beat(4'd4, 1'b1);
        get_result("basic", 1'b1);

        // Carry ripple
        do_start();
        send_beat(4'd15, 1'b0);
        send_beat(4'd11, 1'b0);
        send_beat(4'd6, 1'b1);
        get_result("ripple1", 1'b1);
        do_start();
        send_beat(4'd13, 1'b0);
        send_beat(4'd13, 1'b0);
        send_beat(4'd12, 1'b0);
        send_beat(4'd7, 1'b0);
        send_beat(4'd7, 1'b0);
        send_beat(4'd1, 1'b1);
        get_result("ripple2", 1'b0);

        // Auto-terminate after MAX_OPS beats
        do_start();
        for (int i = 0; i < MAX_OPS; i++) send_beat(4'd15, 1'b0);
        check("auto_ready_drop", in_ready, 0);
        in_valid = 1'b1; in_data = 4'd15; in_last = 1'b1;
        get_result("auto", 1'b0);
        step();
        check("auto_ninth_ignored", in_ready, 0);
        in_valid = 1'b0; in_last = 1'b0;

        // Backpressure with ignored start pulses in DONE
        out_ready = 1'b0;
        do_start();
        send_beat(4'd15, 1'b0);
        send_beat(4'd11, 1'b0);
        send_beat(4'd6, 1'b1);
        get_result("bp", 1'b0);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            step();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_sum", out_sum, last_sum);
            check("bp_hold_count", out_count, last_cnt);
        end
        start = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_handshake_valid", out_valid, 0);
        check("bp_handshake_idle", in_ready, 0);
        step();
        check("bp_still_idle", in_ready, 0);

        // Reset mid-ACC
        do_start();
        send_beat(4'd13, 1'b0);
        send_beat(4'd9, 1'b0);
        rst = 1'b1;
        #2;
        check_zero("rst_mid_acc");
        step();
        rst = 1'b0;
        step();
        do_start();
        send_beat(4'd5, 1'b0);
        send_beat(4'd3, 1'b1);
        get_result("after_rst", 1'b1);

        // Reset mid-DONE discards the pending result
        out_ready = 1'b0;
        do_start();
        send_beat(4'd2, 1'b1);
        get_result("pre_rst_done", 1'b0);
        rst = 1'b1;
        #2;
        check_zero("rst_mid_done");
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();

        // Stalled stream: in_valid toggles every other cycle
        do_start();
        send_beat(4'b1101, 1'b0);
        step();
        send_beat(4'b1001, 1'b0);
        step();
        send_beat(4'b0100, 1'b1);
        get_result("stall", 1'b0);

`ifdef CSA_SIGNED_EN
        do_start();
        send_beat(4'b1101, 1'b0);
        send_beat(4'b1001, 1'b0);
        send_beat(4'b0100, 1'b1);
        get_result("signed", 1'b1);
        check("signed_total", last_sum, 8'hFA);
`endif

        check("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
